// File: rtl/fetch_if.sv
// Fetch front-end bus: redirect/stall/halt controls from the pipeline,
// the instruction-memory req/ack channel and the queue-head view for IF/ID.
interface fetch_if #(
  parameter int PC_WIDTH          = 9,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int QUEUE_DEPTH       = 2
);
  logic                               Redirect;
  logic [PC_WIDTH-1:0]                RedirectPC;
  logic                               Stall;
  logic                               Halt;
  logic                               MemReq;
  logic [PC_WIDTH-1:0]                MemAddr;
  logic                               MemAck;
  logic [INSTRUCTION_WIDTH-1:0]       MemRData;
  logic                               InstrValid;
  logic [PC_WIDTH-1:0]                InstrPC;
  logic [INSTRUCTION_WIDTH-1:0]       Instr;
  logic [$clog2(QUEUE_DEPTH):0]       QueueCount;

  // fetch unit side
  modport master (
    input  Redirect, RedirectPC, Stall, Halt, MemAck, MemRData,
    output MemReq, MemAddr, InstrValid, InstrPC, Instr, QueueCount
  );

  // pipeline / memory side
  modport slave (
    output Redirect, RedirectPC, Stall, Halt, MemAck, MemRData,
    input  MemReq, MemAddr, InstrValid, InstrPC, Instr, QueueCount
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one
// instruction-memory request outstanding and buffers returned words in a
// small prefetch queue feeding IF/ID.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | no request outstanding
//   S_WAIT    | request outstanding, data will be pushed on ack
//   S_DISCARD | request outstanding after a redirect, data dropped on ack
module fetch_unit #(
  parameter int                  PC_WIDTH          = 9,
  parameter int                  INSTRUCTION_WIDTH = 32,
  parameter int                  QUEUE_DEPTH       = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master fetch_bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic                         r_mem_req;
  logic                         w_mem_req_nxt;
  logic [PC_WIDTH-1:0]          r_mem_addr;
  logic [PC_WIDTH-1:0]          w_mem_addr_nxt;
  logic [PC_WIDTH-1:0]          r_fetch_pc;
  logic [PC_WIDTH-1:0]          w_fetch_pc_nxt;
  logic [PC_WIDTH-1:0]          w_addr_inc;

  logic [PC_WIDTH-1:0]          r_q_pc    [QUEUE_DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] r_q_instr [QUEUE_DEPTH];
  logic [PTR_W-1:0]             r_head;
  logic [PTR_W-1:0]             r_tail;
  logic [CNT_W-1:0]             r_count;
  logic [CNT_W-1:0]             w_count_after;

  logic                         w_valid;
  logic                         w_pop;
  logic                         w_push;
  logic                         w_can_issue;

  // Redirect outranks everything: no push or pop in a redirect cycle.
  assign w_valid       = (r_count != '0);
  assign w_pop         = w_valid && !fetch_bus.Stall && !fetch_bus.Redirect;
  assign w_push        = (r_state == S_WAIT) && fetch_bus.MemAck && !fetch_bus.Redirect;
  assign w_count_after = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  // Issuing only when a slot is free after this cycle reserves room for the
  // returning word, so a push can never overflow the queue.
  assign w_can_issue   = !fetch_bus.Halt && !fetch_bus.Redirect &&
                         (w_count_after < CNT_W'(QUEUE_DEPTH));
  assign w_addr_inc    = r_mem_addr + PC_WIDTH'(4);

  // State register together with the registered request outputs and fetch PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  // Next-state, request and fetch-PC decisions for the request channel.
  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_fetch_pc_nxt = r_fetch_pc;

    if (fetch_bus.Redirect) begin
      w_fetch_pc_nxt = fetch_bus.RedirectPC;
    end

    case (r_state)
      S_IDLE: begin
        if (w_can_issue) begin
          w_state_nxt    = S_WAIT;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = r_fetch_pc;
        end
      end
      S_WAIT: begin
        if (fetch_bus.Redirect) begin
          if (fetch_bus.MemAck) begin
            w_state_nxt   = S_IDLE;
            w_mem_req_nxt = 1'b0;
          end else begin
            // request cannot be aborted; keep req/addr held until ack
            w_state_nxt = S_DISCARD;
          end
        end else if (fetch_bus.MemAck) begin
          w_fetch_pc_nxt = w_addr_inc;
          if (w_can_issue) begin
            w_mem_addr_nxt = w_addr_inc;
          end else begin
            w_state_nxt   = S_IDLE;
            w_mem_req_nxt = 1'b0;
          end
        end
      end
      S_DISCARD: begin
        if (fetch_bus.MemAck) begin
          w_state_nxt   = S_IDLE;
          w_mem_req_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // Prefetch queue: circular buffer, cleared wholesale on redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else if (fetch_bus.Redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_q_pc[r_tail]    <= r_mem_addr;
        r_q_instr[r_tail] <= fetch_bus.MemRData;
        r_tail            <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= w_count_after;
    end
  end

  assign fetch_bus.MemReq     = r_mem_req;
  assign fetch_bus.MemAddr    = r_mem_addr;
  assign fetch_bus.InstrValid = w_valid;
  // empty queue presents an all-zero bubble to IF/ID
  assign fetch_bus.InstrPC    = w_valid ? r_q_pc[r_head]    : '0;
  assign fetch_bus.Instr      = w_valid ? r_q_instr[r_head] : '0;
  assign fetch_bus.QueueCount = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a queue-based model.
module tb_fetch_unit;
  localparam int PW = 9;
  localparam int IW = 32;
  localparam int QD = 2;

  typedef struct {
    logic [PW-1:0] pc;
    logic [IW-1:0] ins;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW), .QUEUE_DEPTH(QD)) bus ();
  fetch_if #(.PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW), .QUEUE_DEPTH(QD)) bus2 ();

  fetch_unit #(.PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW), .QUEUE_DEPTH(QD),
               .RESET_PC(9'h000))
    u_dut (.clk(clk), .rst(rst), .fetch_bus(bus));

  fetch_unit #(.PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW), .QUEUE_DEPTH(QD),
               .RESET_PC(9'h1FC))
    u_wrap (.clk(clk), .rst(rst), .fetch_bus(bus2));

  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return {a[7:0] ^ 8'h5A, 7'h35, a, ~a[7:0]};
  endfunction

  // wrap instance: zero-wait memory, never stalled
  assign bus2.Redirect   = 1'b0;
  assign bus2.RedirectPC = '0;
  assign bus2.Stall      = 1'b0;
  assign bus2.Halt       = 1'b0;
  assign bus2.MemAck     = bus2.MemReq;
  assign bus2.MemRData   = mem_word(bus2.MemAddr);

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  ent_t          m_q[$];
  logic          m_req;
  logic [PW-1:0] m_addr;
  logic [PW-1:0] m_fpc;
  logic          m_disc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_req  = 1'b0;
    m_addr = '0;
    m_fpc  = 9'h000;
    m_disc = 1'b0;
  endtask

  // One clock of fetch behaviour from the rules: queue ops, then request side.
  task automatic model_step(input bit redir, input logic [PW-1:0] rpc, input bit stall,
                            input bit halt, input bit ack, input logic [IW-1:0] rdata);
    int n;
    int after;
    bit pop;
    bit ackd;
    bit push;
    bit can;
    logic [PW-1:0] nxt;
    n     = m_q.size();
    pop   = (n > 0) && !stall && !redir;
    ackd  = m_req && ack;
    push  = ackd && !m_disc && !redir;
    after = n + int'(push) - int'(pop);
    can   = !halt && !redir && (after < QD);
    nxt   = m_addr + 9'd4;
    if (redir) begin
      m_q.delete();
      m_fpc = rpc;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back('{pc: m_addr, ins: rdata});
        m_fpc = nxt;
      end
    end
    if (m_req) begin
      if (ackd) begin
        if (push && can) m_addr = nxt;
        else m_req = 1'b0;
        m_disc = 1'b0;
      end else if (redir) begin
        m_disc = 1'b1;
      end
    end else if (can) begin
      m_req  = 1'b1;
      m_addr = m_fpc;
    end
  endtask

  // Called at a falling edge; drives one cycle of inputs, returns at the next falling edge.
  task automatic drive(input bit redir, input logic [PW-1:0] rpc, input bit stall,
                       input bit halt, input bit ack);
    logic [IW-1:0] rd;
    #1;
    rd = (ack && m_req) ? mem_word(m_addr) : IW'($urandom());
    bus.Redirect   = redir;
    bus.RedirectPC = rpc;
    bus.Stall      = stall;
    bus.Halt       = halt;
    bus.MemAck     = ack;
    bus.MemRData   = rd;
    model_step(redir, rpc, stall, halt, ack, rd);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit async_chk);
    #2;
    rst    = 1'b1;
    chk_en = 1'b0;
    bus.Redirect = 1'b0; bus.RedirectPC = '0; bus.Stall = 1'b0;
    bus.Halt = 1'b0; bus.MemAck = 1'b0; bus.MemRData = '0;
    if (async_chk) begin
      #1;
      chk("async MemReq", 32'(bus.MemReq), 32'd0);
      chk("async InstrValid", 32'(bus.InstrValid), 32'd0);
      chk("async QueueCount", 32'(bus.QueueCount), 32'd0);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("InstrValid", 32'(bus.InstrValid), 32'(m_q.size() != 0));
      chk("QueueCount", 32'(bus.QueueCount), 32'(m_q.size()));
      chk("InstrPC", 32'(bus.InstrPC), (m_q.size() != 0) ? 32'(m_q[0].pc) : 32'd0);
      chk("Instr", bus.Instr, (m_q.size() != 0) ? m_q[0].ins : 32'd0);
      chk("MemReq", 32'(bus.MemReq), 32'(m_req));
      if (m_req) chk("MemAddr", 32'(bus.MemAddr), 32'(m_addr));
    end
  end

  initial begin
    bus.Redirect = 1'b0; bus.RedirectPC = '0; bus.Stall = 1'b0;
    bus.Halt = 1'b0; bus.MemAck = 1'b0; bus.MemRData = '0;
    model_reset();
    @(negedge clk);
    chk("reset MemReq", 32'(bus.MemReq), 32'd0);
    chk("reset MemAddr", 32'(bus.MemAddr), 32'd0);
    chk("reset InstrPC", 32'(bus.InstrPC), 32'd0);
    chk("reset Instr", bus.Instr, 32'd0);
    do_reset(1'b0);

    // sequential fetch, ack every request cycle
    drive(0, '0, 0, 0, 0);
    chk("seq addr0", 32'(bus.MemAddr), 32'h000);
    chk("seq req0", 32'(bus.MemReq), 32'd1);
    chk("wrap addr0", 32'(bus2.MemAddr), 32'h1FC);
    drive(0, '0, 0, 0, 1);
    chk("seq addr1", 32'(bus.MemAddr), 32'h004);
    chk("seq pc0", 32'(bus.InstrPC), 32'h000);
    chk("seq instr0", bus.Instr, mem_word(9'h000));
    chk("wrap addr1", 32'(bus2.MemAddr), 32'h000);
    chk("wrap pc0", 32'(bus2.InstrPC), 32'h1FC);
    drive(0, '0, 0, 0, 1);
    chk("seq addr2", 32'(bus.MemAddr), 32'h008);
    chk("seq pc1", 32'(bus.InstrPC), 32'h004);
    drive(0, '0, 0, 0, 1);
    chk("seq addr3", 32'(bus.MemAddr), 32'h00C);
    chk("seq pc2", 32'(bus.InstrPC), 32'h008);

    // redirect while waiting on 0x00C; its data must be dropped
    drive(0, '0, 1, 0, 0);
    chk("redir pre count", 32'(bus.QueueCount), 32'd1);
    drive(1, 9'h040, 0, 0, 0);
    chk("redir count", 32'(bus.QueueCount), 32'd0);
    chk("redir held addr", 32'(bus.MemAddr), 32'h00C);
    drive(0, '0, 0, 0, 1);
    chk("discard dropped", 32'(bus.QueueCount), 32'd0);
    chk("discard req", 32'(bus.MemReq), 32'd0);
    drive(0, '0, 0, 0, 0);
    chk("redir new addr", 32'(bus.MemAddr), 32'h040);
    drive(0, '0, 0, 0, 1);
    chk("redir first pc", 32'(bus.InstrPC), 32'h040);

    // redirect coincident with ack
    drive(1, 9'h080, 0, 0, 1);
    chk("redir+ack req", 32'(bus.MemReq), 32'd0);
    chk("redir+ack count", 32'(bus.QueueCount), 32'd0);
    drive(0, '0, 0, 0, 0);
    chk("redir+ack addr", 32'(bus.MemAddr), 32'h080);

    // async reset mid-wait
    chk("pre-async req", 32'(bus.MemReq), 32'd1);
    do_reset(1'b1);
    drive(0, '0, 0, 0, 0);
    chk("restart addr", 32'(bus.MemAddr), 32'h000);

    // stall with two-cycle memory until full, then release
    do_reset(1'b0);
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 1);
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 1);
    chk("full count", 32'(bus.QueueCount), 32'd2);
    chk("full req", 32'(bus.MemReq), 32'd0);
    chk("full head", 32'(bus.InstrPC), 32'h000);
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    chk("full head held", 32'(bus.InstrPC), 32'h000);
    chk("full req held", 32'(bus.MemReq), 32'd0);
    drive(0, '0, 0, 0, 0);
    chk("release head", 32'(bus.InstrPC), 32'h004);
    chk("release addr", 32'(bus.MemAddr), 32'h008);
    chk("release req", 32'(bus.MemReq), 32'd1);

    // randomized phases with varying pressure
    for (int ph = 0; ph < 3; ph++) begin
      int ack_pct;
      int stall_pct;
      int halt_pct;
      int redir_pct;
      ack_pct   = (ph == 0) ? 100 : (ph == 1) ? 50 : 25;
      stall_pct = (ph == 0) ? 10  : (ph == 1) ? 30 : 60;
      halt_pct  = (ph == 0) ? 0   : 10;
      redir_pct = (ph == 0) ? 3   : 7;
      for (int c = 0; c < 1200; c++) begin
        bit r;
        bit s;
        bit h;
        bit a;
        r = ($urandom_range(99) < redir_pct);
        s = ($urandom_range(99) < stall_pct);
        h = ($urandom_range(99) < halt_pct);
        a = m_req ? ($urandom_range(99) < ack_pct) : ($urandom_range(99) < 20);
        drive(r, PW'($urandom_range(511)), s, h, a);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
